// File: rtl/posit_defines.sv
// Shared definitions for the posit accumulator sequencer: word width,
// accumulator timeout, NaR encoding and the sequencer state encoding.
package posit_defines;

    localparam int NBITS       = 32;
    localparam int ACC_TIMEOUT = 16;

    localparam logic [NBITS-1:0] NAR = {1'b1, {(NBITS-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_FLUSH_WAIT,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_ERROR
    } state_t;

endpackage

// File: rtl/posit_seq_timer.sv
// Down-counting watchdog for one accumulator operation. Loaded when an operand
// is issued, counts while waiting, and flags expiry at terminal count zero.
module posit_seq_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic tick,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(TIMEOUT);
        end else if (tick && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/posit_accum_seq.sv
// Feeds posit terms one at a time into an external accumulator, flushing the
// accumulator's previous sum back to zero before a new sum begins.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | decide between flushing the held result or starting fresh
// FLUSH      | issue the negated held result to cancel the accumulator
// FLUSH_WAIT | wait for the flush result; retry, proceed or fail
// ISSUE      | accept one input term
// WAIT       | wait for the accumulator to return the running sum
// HOLD       | present the completed sum until the consumer takes it
// ERROR      | sticky failure, left only through reset
module posit_accum_seq #(
    parameter int NBITS       = posit_defines::NBITS,
    parameter int ACC_TIMEOUT = posit_defines::ACC_TIMEOUT,
    parameter int MAX_FLUSH   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NBITS-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [NBITS-1:0] acc_in,
    output logic             acc_start,
    input  logic [NBITS-1:0] acc_result,
    input  logic             acc_done,
    input  logic             acc_inf,
    input  logic             acc_zero,
    output logic [NBITS-1:0] sum_data,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             sum_inf,
    output logic [15:0]      sum_terms,
    output logic             err
);

    import posit_defines::*;

    localparam int FW = $clog2(MAX_FLUSH + 2);

    state_t           state;
    state_t           state_next;
    logic [NBITS-1:0] held;
    logic             held_inf;
    logic [15:0]      term_cnt;
    logic [FW-1:0]    flush_cnt;
    logic             last_q;
    logic             expired;
    logic             issue_op;
    logic             flush_op;
    logic             timer_tick;
    logic             held_bad;
    logic             res_zero;
    logic             res_bad;

    assign held_bad = held_inf || (held == NAR);
    assign res_zero = acc_zero || (acc_result == '0);
    assign res_bad  = acc_inf || (acc_result == NAR);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (held_bad) begin
                    state_next = S_ERROR;
                end else if (held == '0) begin
                    state_next = S_ISSUE;
                end else begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: state_next = S_FLUSH_WAIT;
            S_FLUSH_WAIT: begin
                // A done arriving on the expiry cycle still counts as done.
                if (acc_done) begin
                    if (res_zero) begin
                        state_next = S_ISSUE;
                    end else if (res_bad) begin
                        state_next = S_ERROR;
                    end else if (flush_cnt < FW'(MAX_FLUSH)) begin
                        state_next = S_FLUSH;
                    end else begin
                        state_next = S_ERROR;
                    end
                end else if (expired) begin
                    state_next = S_ERROR;
                end
            end
            S_ISSUE: begin
                if (in_valid) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (acc_done) begin
                    state_next = last_q ? S_HOLD : S_ISSUE;
                end else if (expired) begin
                    state_next = S_ERROR;
                end
            end
            S_HOLD: begin
                if (sum_ready) begin
                    state_next = S_IDLE;
                end
            end
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        sum_valid  = 1'b0;
        err        = 1'b0;
        timer_tick = 1'b0;
        issue_op   = 1'b0;
        flush_op   = 1'b0;
        case (state)
            S_FLUSH:      flush_op = 1'b1;
            S_FLUSH_WAIT: timer_tick = 1'b1;
            S_ISSUE: begin
                in_ready = 1'b1;
                issue_op = in_valid;
            end
            S_WAIT:       timer_tick = 1'b1;
            S_HOLD:       sum_valid = 1'b1;
            S_ERROR:      err = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_start <= 1'b0;
            acc_in    <= '0;
            held      <= '0;
            held_inf  <= 1'b0;
            term_cnt  <= '0;
            flush_cnt <= '0;
            last_q    <= 1'b0;
        end else begin
            acc_start <= issue_op || flush_op;
            if (state == S_IDLE) begin
                term_cnt  <= '0;
                flush_cnt <= '0;
            end
            if (issue_op) begin
                acc_in <= in_data;
                last_q <= in_last;
                if (term_cnt != 16'hFFFF) begin
                    term_cnt <= term_cnt + 16'd1;
                end
            end else if (flush_op) begin
                acc_in    <= -held;
                flush_cnt <= flush_cnt + FW'(1);
            end
            if (((state == S_WAIT) || (state == S_FLUSH_WAIT)) && acc_done) begin
                held     <= acc_result;
                held_inf <= res_bad;
            end
        end
    end

    posit_seq_timer #(
        .TIMEOUT (ACC_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (issue_op || flush_op),
        .tick    (timer_tick),
        .expired (expired)
    );

    assign sum_data  = held;
    assign sum_inf   = held_inf;
    assign sum_terms = term_cnt;

endmodule

// File: tb/tb_posit_accum_seq.sv
// Directed bench for posit_accum_seq with a scripted accumulator model whose
// results are queued by the stimulus and returned a fixed latency later.
module tb_posit_accum_seq;

    localparam logic [31:0] NAR = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [31:0] acc_in;
    logic        acc_start;
    logic [31:0] acc_result = '0;
    logic        acc_done = 1'b0;
    logic        acc_inf = 1'b0;
    logic        acc_zero = 1'b0;
    logic [31:0] sum_data;
    logic        sum_valid;
    logic        sum_ready = 1'b0;
    logic        sum_inf;
    logic [15:0] sum_terms;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] res_q[$];
    logic [31:0] pend = '0;
    logic [31:0] pop_v;
    int          lat_cfg = 8;
    int          lat_cnt = 0;
    bit          model_mute = 1'b0;

    posit_accum_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .acc_in     (acc_in),
        .acc_start  (acc_start),
        .acc_result (acc_result),
        .acc_done   (acc_done),
        .acc_inf    (acc_inf),
        .acc_zero   (acc_zero),
        .sum_data   (sum_data),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .sum_inf    (sum_inf),
        .sum_terms  (sum_terms),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Accumulator model: done arrives lat_cfg cycles after the acc_start cycle.
    // It is deliberately not reset, so an op in flight across a reset still lands.
    always @(posedge clk) begin
        acc_done <= 1'b0;
        if (acc_start) begin
            if (res_q.size() > 0) pop_v = res_q.pop_front();
            else pop_v = '0;
            pend    <= pop_v;
            lat_cnt <= model_mute ? 0 : lat_cfg - 1;
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
                acc_done   <= 1'b1;
                acc_result <= pend;
                acc_zero   <= (pend == '0);
                acc_inf    <= (pend == NAR);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return acc_start;
            1: return sum_valid;
            2: return in_ready;
            default: return err;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sig(sel) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        sum_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bit ok;
        int t1, t2;
        bit hold_ok, ir_seen, sv_seen, done_seen;
        int starts;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_sum_valid", sum_valid, 0);
        check("rst_sum_data", sum_data, 0);
        check("rst_sum_terms", sum_terms, 0);
        check("rst_err", err, 0);
        check("rst_acc_start", acc_start, 0);
        reset_n = 1'b1;

        // Two-term sum 1.0 + 1.0
        res_q.push_back(32'h4000_0000);
        res_q.push_back(32'h4800_0000);
        in_data  = 32'h4000_0000;
        in_last  = 1'b0;
        in_valid = 1'b1;
        wait_sig(0, 20, ok);
        check("start1_seen", ok, 1);
        t1 = cyc;
        check("start1_acc_in", acc_in, 32'h4000_0000);
        in_last = 1'b1;
        check("wait_in_ready", in_ready, 0);
        wait_sig(0, 30, ok);
        check("start2_seen", ok, 1);
        t2 = cyc;
        check("start_gap", t2 - t1, 10);
        check("start2_acc_in", acc_in, 32'h4000_0000);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_sig(1, 30, ok);
        check("sum1_seen", ok, 1);
        check("sum1_data", sum_data, 32'h4800_0000);
        check("sum1_terms", sum_terms, 2);
        check("sum1_inf", sum_inf, 0);

        // Backpressure: outputs frozen for 20 cycles
        hold_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sum_data !== 32'h4800_0000 || sum_terms !== 16'd2 ||
                sum_valid !== 1'b1 || in_ready !== 1'b0)
                hold_ok = 1'b0;
        end
        check("hold_stable", hold_ok, 1);

        // Next sum starts with a flush of the held 0x48000000
        res_q.push_back(32'h0000_0000);
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        wait_sig(0, 10, ok);
        check("flush_seen", ok, 1);
        check("flush_acc_in", acc_in, 32'hB800_0000);
        check("flush_in_ready", in_ready, 0);
        wait_sig(2, 30, ok);
        check("flush_to_issue", ok, 1);
        check("flush_held_zero", sum_data, 0);
        check("flush_terms_clr", sum_terms, 0);
        check("flush_err", err, 0);

        // Single-term sum, then two failing flushes exhaust MAX_FLUSH
        res_q.push_back(32'h4000_0000);
        res_q.push_back(32'h0000_0001);
        res_q.push_back(32'h0000_0001);
        in_data  = 32'h4000_0000;
        in_last  = 1'b1;
        in_valid = 1'b1;
        wait_sig(0, 10, ok);
        check("one_start", ok, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_sig(1, 30, ok);
        check("one_sum_seen", ok, 1);
        check("one_sum_data", sum_data, 32'h4000_0000);
        check("one_sum_terms", sum_terms, 1);
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        wait_sig(0, 10, ok);
        check("fl1_seen", ok, 1);
        check("fl1_acc_in", acc_in, 32'hC000_0000);
        wait_sig(0, 30, ok);
        check("fl2_seen", ok, 1);
        check("fl2_acc_in", acc_in, 32'hFFFF_FFFF);
        wait_sig(3, 30, ok);
        check("flush_fail_err", ok, 1);
        check("flush_fail_ready", in_ready, 0);
        check("flush_fail_sv", sum_valid, 0);

        // Done on the same cycle the timeout expires wins
        do_reset();
        lat_cfg = 16;
        res_q.push_back(32'h4000_0000);
        in_data  = 32'h4000_0000;
        in_last  = 1'b1;
        in_valid = 1'b1;
        wait_sig(0, 10, ok);
        check("tie_start", ok, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_sig(1, 30, ok);
        check("tie_sum_seen", ok, 1);
        check("tie_err", err, 0);
        check("tie_sum_data", sum_data, 32'h4000_0000);
        lat_cfg = 8;

        // Accumulator never answers: error 17 cycles after acc_start
        do_reset();
        model_mute = 1'b1;
        in_data  = 32'h4000_0000;
        in_last  = 1'b1;
        in_valid = 1'b1;
        wait_sig(0, 10, ok);
        check("to_start", ok, 1);
        t1 = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
        ir_seen = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) ir_seen = 1'b1;
            if (err === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("to_err_seen", ok, 1);
        check("to_err_cycle", cyc - t1, 17);
        check("to_no_ready", ir_seen, 0);
        repeat (3) @(negedge clk);
        check("to_err_sticky", err, 1);
        check("to_ready_low", in_ready, 0);
        model_mute = 1'b0;

        // NaR result: no flush attempted, straight to error
        do_reset();
        res_q.push_back(NAR);
        in_data  = 32'h4000_0000;
        in_last  = 1'b1;
        in_valid = 1'b1;
        wait_sig(0, 10, ok);
        check("nar_start", ok, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_sig(1, 30, ok);
        check("nar_sum_seen", ok, 1);
        check("nar_sum_inf", sum_inf, 1);
        check("nar_sum_data", sum_data, NAR);
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_start === 1'b1) starts++;
        end
        check("nar_no_flush", starts, 0);
        check("nar_err", err, 1);

        // Reset while waiting; the late done must be ignored
        do_reset();
        res_q.push_back(32'h4000_0000);
        in_data  = 32'h4000_0000;
        in_last  = 1'b1;
        in_valid = 1'b1;
        wait_sig(0, 10, ok);
        check("mid_start", ok, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        sv_seen = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (sum_valid === 1'b1) sv_seen = 1'b1;
            if (acc_done === 1'b1) done_seen = 1'b1;
        end
        check("mid_stray_done", done_seen, 1);
        check("mid_no_sum", sv_seen, 0);
        check("mid_in_ready", in_ready, 1);
        check("mid_sum_data", sum_data, 0);
        check("mid_sum_terms", sum_terms, 0);
        check("mid_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/posit_accum_seq.md
POSIT_ACCUM_SEQ -- requirements
Module: posit_accum_seq

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NBITS, 32, posit word width.
- ACC_TIMEOUT, 16, max cycles from acc_start to acc_done.
- MAX_FLUSH, 2, flush attempts before error.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock.
- reset_n, in, 1, synchronous active-low reset.
- in_data, in, NBITS, posit term.
- in_valid, in, 1, term valid.
- in_last, in, 1, final term of the current sum.
- in_ready, out, 1, term accepted when in_valid & in_ready.
- acc_in, out, NBITS, operand to the accumulator.
- acc_start, out, 1, one-cycle operand strobe.
- acc_result, in, NBITS, accumulator running sum.
- acc_done, in, 1, result strobe.
- acc_inf, in, 1, accumulator NaR flag.
- acc_zero, in, 1, accumulator zero flag.
- sum_data, out, NBITS, completed sum.
- sum_valid, out, 1, sum available.
- sum_ready, in, 1, consumer accepts sum.
- sum_inf, out, 1, sum is NaR.
- sum_terms, out, 16, number of terms in sum_data.
- err, out, 1, sticky flush or timeout failure.
REQ-003 The clock is clk; reset is reset_n, synchronous, active-low.

Function
REQ-004 The block SHALL issue at most one accumulator operation in flight and wait for acc_done before the next, because the accumulator feeds back its own result.
REQ-005 States SHALL be IDLE, FLUSH, FLUSH_WAIT, ISSUE, WAIT, HOLD, ERROR.
- IDLE: if the held result is zero, go to ISSUE; otherwise go to FLUSH.
- FLUSH: drive acc_in = two's complement of the held acc_result, pulse acc_start, go to FLUSH_WAIT.
- FLUSH_WAIT: on acc_done, go to ISSUE if acc_result == 0 or acc_zero; else go to FLUSH while attempts < MAX_FLUSH; else go to ERROR.
- ISSUE: in_ready = 1; on handshake, drive acc_in = in_data, pulse acc_start, latch in_last, increment the term counter, go to WAIT.
- WAIT: on acc_done, capture acc_result; go to HOLD if the latched last is set, else go to ISSUE.
- HOLD: sum_valid = 1; on sum_ready, go to IDLE.
REQ-006 in_ready SHALL be 1 only in ISSUE, and is combinational from state only (no path from in_valid).
REQ-007 acc_start SHALL be exactly one cycle wide, and acc_in SHALL be registered with it.
REQ-008 Latency SHALL be 1 cycle from the input handshake to acc_start, and 1 cycle from acc_done to the HOLD/ISSUE transition.
REQ-009 sum_data, sum_inf and sum_terms SHALL stay stable while sum_valid = 1 and sum_ready = 0.
REQ-010 A flush SHALL NOT be attempted when the held result is NaR (0x80000000) or acc_inf = 1; the block SHALL go to ERROR instead.
REQ-011 If acc_done has not arrived ACC_TIMEOUT cycles after acc_start, the block SHALL go to ERROR.
REQ-012 In ERROR: err = 1, in_ready = 0, sum_valid = 0, acc_start = 0; the block remains there until reset.
REQ-013 An acc_done received in IDLE, ISSUE or HOLD SHALL be ignored, and no state SHALL change.
REQ-014 The term counter SHALL saturate at 0xFFFF, clear on the IDLE exit, and drive sum_terms.
REQ-015 Simultaneous acc_done and timeout expiry in the same cycle SHALL be treated as done.

Reset
REQ-016 When reset_n = 0 at a clk edge: state = IDLE, held result = 0, all strobes = 0, in_ready = 0, sum_valid = 0, sum_data = 0, sum_terms = 0, err = 0.
REQ-017 Reset mid-operation SHALL abandon the sum; any late acc_done after reset falls under REQ-013.

Structure
REQ-018 The state enum, the NaR constant and ACC_TIMEOUT SHALL reside in posit_defines; NBITS SHALL be reused from there.
REQ-019 The timeout counter SHALL be a sub-module, posit_seq_timer (load, tick, expired).

Verification
REQ-020 Bench with an accumulator model of latency 8:
- Terms 0x40000000, 0x40000000 (last) → acc_start twice, 9+ cycles apart; sum_data = 0x48000000; sum_terms = 2.
- Held 0x48000000, new sum → FLUSH with acc_in = 0xB8000000; model returns 0 → ISSUE.
- sum_ready low 20 cycles → sum_data stable, in_ready = 0 throughout.
- Model never asserts acc_done → err = 1 at cycle 17 after acc_start; in_ready stays 0.
- Held 0x80000000 → ERROR with no acc_start pulse.
- reset_n low during WAIT, then a stray acc_done → IDLE, no sum_valid.
